// File: rtl/axi_sram_slave.sv
// AXI4 slave front-end for a single-port word SRAM.
// Handles one outstanding INCR burst (up to 16 beats) at a time. Read bursts
// use a fetch/data pair of cycles per beat. Write beats stream at one per cycle
// while WVALID is held.
//
// Handshake rule used on every channel: a transfer happens on the rising edge
// where VALID and READY are both high. VALID never drops before its transfer,
// and the payload stays stable while VALID is high and READY is low.
module axi_sram_slave #(
    parameter int ID_W    = 8,
    parameter int SRAM_AW = 14
) (
    input  logic               ACLK,
    input  logic               ARESETn,
    // read address channel
    input  logic               ARVALID,
    output logic               ARREADY,
    input  logic [31:0]        ARADDR,
    input  logic [ID_W-1:0]    ARID,
    input  logic [3:0]         ARLEN,
    input  logic [2:0]         ARSIZE,
    input  logic [1:0]         ARBURST,
    // read data channel
    output logic               RVALID,
    input  logic               RREADY,
    output logic [31:0]        RDATA,
    output logic [ID_W-1:0]    RID,
    output logic [1:0]         RRESP,
    output logic               RLAST,
    // write address channel
    input  logic               AWVALID,
    output logic               AWREADY,
    input  logic [31:0]        AWADDR,
    input  logic [ID_W-1:0]    AWID,
    input  logic [3:0]         AWLEN,
    input  logic [2:0]         AWSIZE,
    input  logic [1:0]         AWBURST,
    // write data channel
    input  logic               WVALID,
    output logic               WREADY,
    input  logic [31:0]        WDATA,
    input  logic [3:0]         WSTRB,
    input  logic               WLAST,
    // write response channel
    output logic               BVALID,
    input  logic               BREADY,
    output logic [ID_W-1:0]    BID,
    output logic [1:0]         BRESP,
    // SRAM macro
    output logic               CEB,
    output logic [3:0]         WEB,
    output logic [SRAM_AW-1:0] A,
    output logic [31:0]        DI,
    input  logic [31:0]        DO,
    // debug: current FSM state encoding
    output logic [2:0]         dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_FETCH = 3'd1,
        S_RD_DATA  = 3'd2,
        S_WR_DATA  = 3'd3,
        S_WR_RESP  = 3'd4
    } state_t;

    state_t              state_q;
    logic                ready_q;     // address channels open (IDLE only)
    logic [ID_W-1:0]     id_q;
    logic [SRAM_AW-1:0]  addr_q;
    logic [3:0]          len_q;
    logic [3:0]          beat_q;
    logic                werr_q;
    logic                rvalid_q;
    logic                rlast_q;
    logic [ID_W-1:0]     rid_q;
    logic                wready_q;
    logic                bvalid_q;
    logic [ID_W-1:0]     bid_q;
    logic [1:0]          bresp_q;

    logic [SRAM_AW-1:0]  addr_d;
    logic [3:0]          beat_d;
    logic                last_beat;
    logic                wlast_err;
    logic                ar_hs;
    logic                aw_hs;
    logic                w_hs;
    logic                unused_bits;

    // Size, burst type and out-of-range address bits carry no meaning here.
    assign unused_bits = ^{ARSIZE, ARBURST, AWSIZE, AWBURST,
                           ARADDR[31:SRAM_AW+2], ARADDR[1:0],
                           AWADDR[31:SRAM_AW+2], AWADDR[1:0]};

    assign addr_d    = addr_q + SRAM_AW'(1);
    assign beat_d    = beat_q + 4'd1;
    assign last_beat = (beat_q == len_q);
    assign wlast_err = (WLAST != last_beat);

    // Read wins a same-cycle tie: AWREADY is withheld while ARVALID is high.
    assign ARREADY = ready_q;
    assign AWREADY = ready_q & ~ARVALID;
    assign ar_hs   = ARVALID & ready_q;
    assign aw_hs   = AWVALID & AWREADY;
    assign w_hs    = WVALID & wready_q;

    assign RVALID  = rvalid_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;
    assign RRESP   = 2'b00;
    // DO is held by the macro while CEB is high, so it stays stable through a stall.
    assign RDATA   = rvalid_q ? DO : 32'h0;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BID     = bid_q;
    assign BRESP   = bresp_q;

    // SRAM strobes: read fetch cycle, or a write beat in the same cycle as its handshake.
    assign CEB = ~((state_q == S_RD_FETCH) | w_hs);
    assign WEB = w_hs ? ~WSTRB : 4'hF;
    assign A   = addr_q;
    assign DI  = w_hs ? WDATA : 32'h0;

    assign dbg_state_o = state_q;

    // Transaction FSM with registered channel outputs.
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            beat_q   <= '0;
            werr_q   <= 1'b0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            wready_q <= 1'b0;
            bvalid_q <= 1'b0;
            bid_q    <= '0;
            bresp_q  <= 2'b00;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    ready_q <= 1'b1;
                    if (ar_hs) begin
                        id_q    <= ARID;
                        addr_q  <= ARADDR[SRAM_AW+1:2];
                        len_q   <= ARLEN;
                        beat_q  <= '0;
                        ready_q <= 1'b0;
                        state_q <= S_RD_FETCH;
                    end else if (aw_hs) begin
                        id_q     <= AWID;
                        addr_q   <= AWADDR[SRAM_AW+1:2];
                        len_q    <= AWLEN;
                        beat_q   <= '0;
                        ready_q  <= 1'b0;
                        wready_q <= 1'b1;
                        state_q  <= S_WR_DATA;
                    end
                end
                S_RD_FETCH: begin
                    rvalid_q <= 1'b1;
                    rlast_q  <= last_beat;
                    rid_q    <= id_q;
                    state_q  <= S_RD_DATA;
                end
                S_RD_DATA: begin
                    if (RREADY) begin
                        rvalid_q <= 1'b0;
                        rlast_q  <= 1'b0;
                        if (rlast_q) begin
                            ready_q <= 1'b1;
                            state_q <= S_IDLE;
                        end else begin
                            beat_q  <= beat_d;
                            addr_q  <= addr_d;
                            state_q <= S_RD_FETCH;
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_hs) begin
                        beat_q <= beat_d;
                        addr_q <= addr_d;
                        werr_q <= werr_q | wlast_err;
                        // The burst ends on the beat count; WLAST only flags an error.
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bid_q    <= id_q;
                            bresp_q  <= (werr_q | wlast_err) ? 2'b10 : 2'b00;
                            state_q  <= S_WR_RESP;
                        end
                    end
                end
                S_WR_RESP: begin
                    if (BREADY) begin
                        bvalid_q <= 1'b0;
                        werr_q   <= 1'b0;
                        ready_q  <= 1'b1;
                        state_q  <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
